// File: rtl/dcache_req_axi_master_pkg.sv
// Shared dcache request/response types and AXI constants
// used by the dcache-to-AXI master bridge.
package dcache_req_axi_master_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH = 20;
  localparam int unsigned DCACHE_USER_WIDTH = 1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_1B = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic [DCACHE_USER_WIDTH-1:0]  data_wuser;
    logic                          data_req;
    logic                          data_we;
    logic [(XLEN/8)-1:0]           data_be;
    logic [1:0]                    data_size;
    logic [TRANS_ID_BITS-1:0]      data_id;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_t;

  typedef struct packed {
    logic                         data_gnt;
    logic                         data_rvalid;
    logic [TRANS_ID_BITS-1:0]     data_rid;
    logic [XLEN-1:0]              data_rdata;
    logic [DCACHE_USER_WIDTH-1:0] data_ruser;
  } dcache_rsp_t;

  function automatic logic axi_resp_ok(
    input logic [1:0] resp
  );
    return resp == AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_bus_if.sv
// AXI4 bus bundle with master and slave views.
// Widths are set per instance.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 3,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size,
    output aw_burst, aw_lock, aw_cache, aw_prot,
    output aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size,
    output ar_burst, ar_lock, ar_cache, ar_prot,
    output ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size,
    input  aw_burst, aw_lock, aw_cache, aw_prot,
    input  aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size,
    input  ar_burst, ar_lock, ar_cache, ar_prot,
    input  ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/dcache_req_axi_master.sv
// Bridges a dcache request port to a single-outstanding
// AXI4 master issuing single-beat reads and posted writes.
module dcache_req_axi_master
  import dcache_req_axi_master_pkg::*;
#(
  parameter int unsigned IdWidth   = TRANS_ID_BITS,
  parameter int unsigned AddrWidth =
    DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH,
  parameter int unsigned DataWidth = XLEN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  dcache_req_t dcache_req_i,
  output dcache_rsp_t dcache_rsp_o,
  AXI_BUS.master      axi,
  output logic        bus_err_o,
  output logic        busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_RSP
  } state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [IdWidth-1:0]     id_q;
  logic [1:0]             size_q;
  logic [StrbWidth-1:0]   be_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   aw_done_q;
  logic                   w_done_q;
  logic                   err_q;

  logic gnt;
  logic aw_done;
  logic w_done;

  // Grant only while idle and never during reset.
  assign gnt = ~rst_i
             & (state_q == S_IDLE)
             & dcache_req_i.data_req;

  // A channel counts as done if it handshook earlier or does now.
  assign aw_done = aw_done_q | (axi.aw_valid & axi.aw_ready);
  assign w_done  = w_done_q  | (axi.w_valid & axi.w_ready);

  // Transaction sequencer and captured request/response state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      size_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt) begin
            addr_q <= {dcache_req_i.address_tag,
                       dcache_req_i.address_index};
            id_q   <= dcache_req_i.data_id;
            size_q <= dcache_req_i.data_size;
            be_q   <= dcache_req_i.data_be;
            if (dcache_req_i.data_we) begin
              wdata_q   <= dcache_req_i.data_wdata;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_WR;
            end else begin
              state_q <= S_TAG;
            end
          end
        end
        S_TAG: begin
          if (dcache_req_i.kill_req) begin
            state_q <= S_IDLE;
          end else if (dcache_req_i.tag_valid) begin
            addr_q[AddrWidth-1:DCACHE_INDEX_WIDTH] <=
              dcache_req_i.address_tag;
            state_q <= S_AR;
          end
        end
        S_AR: begin
          if (axi.ar_ready) begin
            state_q <= S_R;
          end
        end
        S_R: begin
          if (axi.r_valid) begin
            rdata_q <= axi.r_data;
            err_q   <= ~axi_resp_ok(axi.r_resp);
            state_q <= S_RSP;
          end
        end
        S_RSP: begin
          state_q <= S_IDLE;
        end
        S_WR: begin
          aw_done_q <= aw_done;
          w_done_q  <= w_done;
          if (aw_done && w_done) begin
            state_q <= S_B;
          end
        end
        S_B: begin
          if (axi.b_valid) begin
            err_q   <= ~axi_resp_ok(axi.b_resp);
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign axi.ar_valid = (state_q == S_AR);
  assign axi.ar_id    = id_q;
  assign axi.ar_addr  = addr_q;
  assign axi.ar_len   = 8'd0;
  assign axi.ar_size  = {1'b0, size_q};
  assign axi.ar_burst = AXI_BURST_INCR;
  assign axi.ar_lock  = 1'b0;
  assign axi.ar_cache = 4'd0;
  assign axi.ar_prot  = 3'd0;
  assign axi.ar_qos   = 4'd0;
  assign axi.ar_user  = '0;

  assign axi.r_ready = (state_q == S_R);

  assign axi.aw_valid = (state_q == S_WR) & ~aw_done_q;
  assign axi.aw_id    = id_q;
  assign axi.aw_addr  = addr_q;
  assign axi.aw_len   = 8'd0;
  assign axi.aw_size  = {1'b0, size_q};
  assign axi.aw_burst = AXI_BURST_INCR;
  assign axi.aw_lock  = 1'b0;
  assign axi.aw_cache = 4'd0;
  assign axi.aw_prot  = 3'd0;
  assign axi.aw_qos   = 4'd0;
  assign axi.aw_user  = '0;

  assign axi.w_valid = (state_q == S_WR) & ~w_done_q;
  assign axi.w_data  = wdata_q;
  assign axi.w_strb  = be_q;
  assign axi.w_last  = 1'b1;
  assign axi.w_user  = '0;

  assign axi.b_ready = (state_q == S_B);

  assign dcache_rsp_o.data_gnt    = gnt;
  assign dcache_rsp_o.data_rvalid = (state_q == S_RSP);
  assign dcache_rsp_o.data_rid    = id_q;
  assign dcache_rsp_o.data_rdata  = rdata_q;
  assign dcache_rsp_o.data_ruser  = '0;

  assign bus_err_o = err_q;
  assign busy_o    = (state_q != S_IDLE);

  logic unused_inputs;
  assign unused_inputs = ^{dcache_req_i.data_wuser,
                           axi.r_id, axi.r_user,
                           axi.b_id, axi.b_user};

  // Single-beat reads must always come back as the last beat.
  r_last_a : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q == S_R && axi.r_valid) |-> axi.r_last
  );

  // A granted store must carry its tag in the grant cycle.
  st_tag_a : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (gnt && dcache_req_i.data_we) |-> dcache_req_i.tag_valid
  );

endmodule
